// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master round-robin arbiter with bounded lock in front of the data memory.
// Defining DM_ARB_STATS_EN adds saturating grant/conflict/misalignment statistics counters.
module dm_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int HOLD_W    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [1:0]  m0_size,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_err,
  output logic        m1_err,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd
`ifdef DM_ARB_STATS_EN
  ,
  output logic [31:0] stat_gnt0,
  output logic [31:0] stat_gnt1,
  output logic [31:0] stat_conflict,
  output logic [15:0] stat_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state;
  logic              last_gnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic        own0_ok;
  logic        own1_ok;
  logic        any_gnt;
  logic        sel_we;
  logic        sel_lock;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_mis;
  logic        ld_ok;

  logic        m0_vld_p1;
  logic        m1_vld_p1;
  logic        m0_err_p1;
  logic        m1_err_p1;
  logic [31:0] m0_rdata_p1;
  logic [31:0] m1_rdata_p1;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = off[0];
      default: is_misaligned = (off != 2'd0);
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    byte_enables = 4'b0001 << off;
      2'd1:    byte_enables = off[1] ? 4'b1100 : 4'b0011;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  // Move the addressed lane down to bit 0 and zero-extend to the access size.
  function automatic logic [31:0] align_load(input logic [31:0] word, input logic [1:0] size,
                                             input logic [1:0] off);
    logic [31:0] shifted;
    shifted = word >> {off, 3'b000};
    case (size)
      2'd0:    align_load = {24'h000000, shifted[7:0]};
      2'd1:    align_load = {16'h0000, shifted[15:0]};
      default: align_load = shifted;
    endcase
  endfunction

  // Grant selection: an owner keeps the bus unless the other master has waited a full burst.
  always_comb begin
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    own0_ok = (state == OWN0) && m0_req && (!m1_req || (hold_cnt < HOLD_W'(MAX_BURST)));
    own1_ok = (state == OWN1) && m1_req && (!m0_req || (hold_cnt < HOLD_W'(MAX_BURST)));
    if (own0_ok) begin
      m0_gnt = 1'b1;
    end else if (own1_ok) begin
      m1_gnt = 1'b1;
    end else if (m0_req && m1_req) begin
      if (last_gnt) m0_gnt = 1'b1;
      else          m1_gnt = 1'b1;
    end else if (m0_req) begin
      m0_gnt = 1'b1;
    end else if (m1_req) begin
      m1_gnt = 1'b1;
    end
  end

  always_comb begin
    any_gnt   = m0_gnt | m1_gnt;
    sel_we    = m1_gnt ? m1_we    : m0_we;
    sel_lock  = m1_gnt ? m1_lock  : m0_lock;
    sel_size  = m1_gnt ? m1_size  : m0_size;
    sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
    sel_mis   = any_gnt && is_misaligned(sel_size, sel_addr[1:0]);
    ld_ok     = any_gnt && !sel_we && !sel_mis;
    dm_we     = any_gnt && sel_we && !sel_mis;
    dm_be     = (any_gnt && !sel_mis) ? byte_enables(sel_size, sel_addr[1:0]) : 4'b0000;
    dm_addr   = sel_addr;
    dm_wd     = sel_wdata;
  end

  // Stage p0 -> p1: arbitration state and registered load/error returns.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_gnt    <= 1'b1;
      hold_cnt    <= '0;
      m0_vld_p1   <= 1'b0;
      m1_vld_p1   <= 1'b0;
      m0_err_p1   <= 1'b0;
      m1_err_p1   <= 1'b0;
      m0_rdata_p1 <= 32'h0;
      m1_rdata_p1 <= 32'h0;
    end else begin
      m0_vld_p1 <= ld_ok && m0_gnt;
      m1_vld_p1 <= ld_ok && m1_gnt;
      m0_err_p1 <= sel_mis && m0_gnt;
      m1_err_p1 <= sel_mis && m1_gnt;
      if (ld_ok && m0_gnt) m0_rdata_p1 <= align_load(dm_rd, sel_size, sel_addr[1:0]);
      if (ld_ok && m1_gnt) m1_rdata_p1 <= align_load(dm_rd, sel_size, sel_addr[1:0]);

      if (any_gnt) last_gnt <= m1_gnt;

      if (any_gnt && sel_lock) begin
        state <= m1_gnt ? OWN1 : OWN0;
        if (state == (m1_gnt ? OWN1 : OWN0)) begin
          // Saturate so an uncontested owner never wraps back below the limit.
          if (hold_cnt < HOLD_W'(MAX_BURST)) hold_cnt <= hold_cnt + 1'b1;
        end else begin
          hold_cnt <= HOLD_W'(1);
        end
      end else begin
        state    <= IDLE;
        hold_cnt <= '0;
      end
    end
  end

  assign m0_rvalid = m0_vld_p1;
  assign m1_rvalid = m1_vld_p1;
  assign m0_err    = m0_err_p1;
  assign m1_err    = m1_err_p1;
  assign m0_rdata  = m0_rdata_p1;
  assign m1_rdata  = m1_rdata_p1;

`ifdef DM_ARB_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_gnt0     <= 32'h0;
      stat_gnt1     <= 32'h0;
      stat_conflict <= 32'h0;
      stat_misalign <= 16'h0;
    end else begin
      if (m0_gnt)            stat_gnt0     <= sat_inc32(stat_gnt0);
      if (m1_gnt)            stat_gnt1     <= sat_inc32(stat_gnt1);
      if (m0_req && m1_req)  stat_conflict <= sat_inc32(stat_conflict);
      if (sel_mis)           stat_misalign <= sat_inc16(stat_misalign);
    end
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios followed by random traffic,
// compared against a cycle-level reference model and a shadow memory.
module tb_dm_arbiter;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_lock, m1_lock, m0_we, m1_we;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wd, dm_rd;
`ifdef DM_ARB_STATS_EN
  logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
  logic [15:0] stat_misalign;
`endif

  dm_arbiter #(.MAX_BURST(MAX_BURST), .HOLD_W(3)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
    .m0_we(m0_we), .m1_we(m1_we), .m0_size(m0_size), .m1_size(m1_size),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_err(m0_err), .m1_err(m1_err),
    .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_rd(dm_rd)
`ifdef DM_ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1),
    .stat_conflict(stat_conflict), .stat_misalign(stat_misalign)
`endif
  );

  always #5 clk = ~clk;

  // Data memory: it takes low-aligned store data and steers it onto the enabled lanes.
  logic [31:0] mem [0:4095] = '{default: 32'h0};
  assign dm_rd = mem[dm_addr[13:2]];

  function automatic logic [31:0] dm_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    int lo;
    logic [31:0] r;
    r  = old;
    lo = -1;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        if (lo < 0) lo = b;
        r[8*b +: 8] = wd[8*(b-lo) +: 8];
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr[13:2]] <= dm_merge(mem[dm_addr[13:2]], dm_wd, dm_be);
  end

  // Reference model state
  int          checks, errors;
  int          own, burst, last;
  logic [31:0] ref_mem [0:4095] = '{default: 32'h0};
  bit          exp_rv  [2];
  bit          exp_err [2];
  logic [31:0] exp_rd  [2];
  logic        obs_g0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst,
                      input bit r0, input bit l0, input bit w0, input logic [1:0] s0,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input bit r1, input bit l1, input bit w1, input logic [1:0] s1,
                      input logic [31:0] a1, input logic [31:0] d1);
    bit          req [2];
    bit          lck [2];
    bit          wr  [2];
    logic [1:0]  sz  [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    int          g, nb, off;
    bit          mis;
    logic [3:0]  be;
    logic [31:0] word;
    logic [11:0] idx;
    req[0] = r0; lck[0] = l0; wr[0] = w0; sz[0] = s0; ad[0] = a0; wd[0] = d0;
    req[1] = r1; lck[1] = l1; wr[1] = w1; sz[1] = s1; ad[1] = a1; wd[1] = d1;
    reset = rst;
    m0_req = r0; m0_lock = l0; m0_we = w0; m0_size = s0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_lock = l1; m1_we = w1; m1_size = s1; m1_addr = a1; m1_wdata = d1;
    #1;
    obs_g0 = m0_gnt;
    check("rvalid0", {31'h0, m0_rvalid}, {31'h0, exp_rv[0]});
    check("rvalid1", {31'h0, m1_rvalid}, {31'h0, exp_rv[1]});
    check("err0", {31'h0, m0_err}, {31'h0, exp_err[0]});
    check("err1", {31'h0, m1_err}, {31'h0, exp_err[1]});
    check("rdata0", m0_rdata, exp_rd[0]);
    check("rdata1", m1_rdata, exp_rd[1]);
    if (rst) begin
      own = -1; burst = 0; last = 1;
      for (int i = 0; i < 2; i++) begin
        exp_rv[i] = 1'b0; exp_err[i] = 1'b0; exp_rd[i] = 32'h0;
      end
    end else begin
      g = -1;
      if (own >= 0 && req[own] && (!req[1-own] || burst < MAX_BURST)) g = own;
      else if (req[0] && req[1]) g = 1 - last;
      else if (req[0]) g = 0;
      else if (req[1]) g = 1;
      check("gnt0", {31'h0, m0_gnt}, {31'h0, (g == 0)});
      check("gnt1", {31'h0, m1_gnt}, {31'h0, (g == 1)});
      for (int i = 0; i < 2; i++) begin
        exp_rv[i] = 1'b0; exp_err[i] = 1'b0;
      end
      if (g >= 0) begin
        nb  = (sz[g] == 2'd0) ? 1 : (sz[g] == 2'd1) ? 2 : 4;
        off = int'(ad[g][1:0]);
        idx = ad[g][13:2];
        mis = (nb == 2 && ad[g][0]) || (nb == 4 && ad[g][1:0] != 2'd0);
        be  = mis ? 4'b0000 : 4'(((1 << nb) - 1) << off);
        check("dm_we", {31'h0, dm_we}, {31'h0, (wr[g] && !mis)});
        check("dm_be", {28'h0, dm_be}, {28'h0, be});
        check("dm_addr", dm_addr, ad[g]);
        check("dm_wd", dm_wd, wd[g]);
        if (mis) begin
          exp_err[g] = 1'b1;
        end else if (wr[g]) begin
          for (int k = 0; k < nb; k++) ref_mem[idx][8*(off+k) +: 8] = wd[g][8*k +: 8];
        end else begin
          word      = ref_mem[idx] >> (8 * off);
          exp_rd[g] = (nb == 4) ? word : (word & ((32'h1 << (8 * nb)) - 32'h1));
          exp_rv[g] = 1'b1;
        end
        if (lck[g]) begin
          burst = (own == g) ? burst + 1 : 1;
          own   = g;
        end else begin
          own = -1; burst = 0;
        end
        last = g;
      end else begin
        check("dm_we_idle", {31'h0, dm_we}, 32'h0);
        check("dm_be_idle", {28'h0, dm_be}, 32'h0);
        own = -1; burst = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0]  seq;
    bit          rr0, rr1, ll0, ll1, ww0, ww1, rs;
    logic [1:0]  ss0, ss1;
    logic [31:0] aa0, aa1;
    checks = 0; errors = 0;
    own = -1; burst = 0; last = 1;
    for (int i = 0; i < 2; i++) begin
      exp_rv[i] = 1'b0; exp_err[i] = 1'b0; exp_rd[i] = 32'h0;
    end
    reset = 1'b1;
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_size = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_size = 0; m1_addr = 0; m1_wdata = 0;
    @(posedge clk);
    #1;
    step(1, 0,0,0,2'd0,32'h0,32'h0, 0,0,0,2'd0,32'h0,32'h0);

    // Both masters load every cycle without lock: grants alternate starting with master 0
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1,0,0,2'd2,32'h10,32'h0, 1,0,0,2'd2,32'h14,32'h0);
      seq = {seq[4:0], obs_g0};
    end
    check("alt_seq", {28'h0, seq[3:0]}, 32'hA);

    // Byte store by master 1, then word load by master 0
    step(0, 0,0,0,2'd0,32'h0,32'h0, 1,0,1,2'd0,32'h5,32'hAB);
    step(0, 1,0,0,2'd2,32'h4,32'h0, 0,0,0,2'd0,32'h0,32'h0);
    check("ld_word_ab00", m0_rdata, 32'h0000AB00);

    // Bounded lock: master 1 alone first so master 0 wins the opening tie
    step(0, 0,0,0,2'd0,32'h0,32'h0, 1,0,0,2'd2,32'h0,32'h0);
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1,1,0,2'd2,32'h0,32'h0, 1,0,0,2'd2,32'h4,32'h0);
      seq = {seq[4:0], obs_g0};
    end
    check("burst_seq", {26'h0, seq}, 32'h3D);

    // Misaligned half load
    step(0, 1,0,0,2'd1,32'h3,32'h0, 0,0,0,2'd0,32'h0,32'h0);
    check("mis_err0", {31'h0, m0_err}, 32'h1);
    check("mis_rvalid0", {31'h0, m0_rvalid}, 32'h0);

    // Word store then upper-half load
    step(0, 1,0,1,2'd2,32'h8,32'h12345678, 0,0,0,2'd0,32'h0,32'h0);
    step(0, 0,0,0,2'd0,32'h0,32'h0, 1,0,0,2'd1,32'hA,32'h0);
    check("ld_half_1234", m1_rdata, 32'h00001234);

    // Reset while master 0 owns the lock with a load in flight
    step(0, 1,1,0,2'd2,32'h8,32'h0, 0,0,0,2'd0,32'h0,32'h0);
    step(1, 1,1,0,2'd2,32'h8,32'h0, 0,0,0,2'd0,32'h0,32'h0);
    check("rst_rvalid0", {31'h0, m0_rvalid}, 32'h0);
    step(0, 1,0,0,2'd2,32'h0,32'h0, 1,0,0,2'd2,32'h4,32'h0);
    check("rst_tie_gnt0", {31'h0, obs_g0}, 32'h1);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rs  = ($urandom_range(0, 99) == 0);
      rr0 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0);
      ll0 = ($urandom_range(0, 2) != 0);
      ll1 = ($urandom_range(0, 2) != 0);
      ww0 = rs ? 1'b0 : 1'($urandom_range(0, 1));
      ww1 = rs ? 1'b0 : 1'($urandom_range(0, 1));
      ss0 = 2'($urandom_range(0, 3));
      ss1 = 2'($urandom_range(0, 3));
      aa0 = 32'($urandom_range(0, 15) * 4 + ($urandom_range(0, 1) ? $urandom_range(0, 3) : 0));
      aa1 = 32'($urandom_range(0, 15) * 4 + ($urandom_range(0, 1) ? $urandom_range(0, 3) : 0));
      step(rs, rr0, ll0, ww0, ss0, aa0, $urandom, rr1, ll1, ww1, ss1, aa1, $urandom);
    end
    step(0, 0,0,0,2'd0,32'h0,32'h0, 0,0,0,2'd0,32'h0,32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-master arbiter and access sequencer in front of the single-port data memory (4096 x 32, byte-enabled, synchronous write, combinational read).
- Master 0 is the CPU memory stage; master 1 is the DMA/debug port.
- Translates size and address into DM byte enables and flags misaligned accesses.
- Round-robin arbitration with a bounded lock (burst) mechanism; read data is returned registered, lane-aligned.

Parameters:
- MAX_BURST, 4, max consecutive locked grants to one master while the other is requesting (>=1).
- HOLD_W, 3, width of the burst hold counter (must represent MAX_BURST).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  access request
- m0_lock, m1_lock  in  1  request to keep ownership next cycle
- m0_we, m1_we  in  1  1 = store, 0 = load
- m0_size, m1_size  in  2  0 = byte, 1 = half, 2 = word; 3 = reserved, treated as word
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0])
- m0_gnt, m1_gnt  out  1  combinational grant; access executes this cycle
- m0_rvalid, m1_rvalid  out  1  registered load-data valid pulse
- m0_rdata, m1_rdata  out  32  registered load data, zero-extended
- m0_err, m1_err  out  1  registered misaligned-access pulse
- dm_we  out  1  DM write enable
- dm_be  out  4  DM byte enable
- dm_addr  out  32  DM address (granted master's addr)
- dm_wd  out  32  DM write data (granted wdata, unmodified)
- dm_rd  in  32  DM read word

Behaviour:
- Reset:
  - All gnt/rvalid/err = 0; rdata = 0.
  - state = IDLE; last_gnt = 1, so master 0 wins the first tie; hold_cnt = 0.
- States:
  - IDLE: no lock held.
  - OWN0 / OWN1: the master was granted last cycle with lock=1.
- Grant selection (combinational, at most one gnt per cycle):
  - OWNx with mx_req=1 and (other master idle or hold_cnt < MAX_BURST): grant x.
  - Otherwise, if only one master requests, grant it.
  - If both request, grant the master != last_gnt.
  - No request: no grant; dm_we=0, dm_be=0.
- State update on posedge:
  - Granted master x with mx_lock=1 -> OWNx.
  - hold_cnt increments if the state was already OWNx, else loads 1.
  - Grant without lock, or no grant -> IDLE, hold_cnt=0.
  - last_gnt updates only on a grant.
- Byte enables:
  - byte: 1 << addr[1:0].
  - half: addr[1] ? 4'b1100 : 4'b0011.
  - word: 4'b1111.
- Misaligned access (half with addr[0]=1, word with addr[1:0]!=0):
  - gnt still asserted (request consumed); dm_we=0, dm_be=0.
  - err pulses the next cycle; no rvalid.
- Store: dm_we=1 in the grant cycle; DM writes at that posedge; no rvalid.
- Load:
  - dm_rd is captured at the posedge, shifted right by 8*addr[1:0] and zero-extended to size.
  - Presented on mx_rdata with mx_rvalid=1 for exactly one cycle after the grant.
  - rdata holds its value until the next load to that master.
- Back-to-back: a new grant may occur in the cycle rvalid is high (1 access/cycle throughput).
- Reset mid-operation: any pending rvalid/err is dropped; the lock is released.

Optional Feature:
- Macro: DM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_gnt0, stat_gnt1 (32 bits each): grant counts per master.
  - Adds output stat_conflict (32 bits): cycles where both req=1.
  - Adds output stat_misalign (16 bits): misaligned accesses.
  - All counters saturate at max and clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Both masters request loads every cycle, no lock -> grants alternate 0,1,0,1 starting with master 0; each rvalid follows its grant by 1 cycle.
- m1 store byte 0xAB at 0x0000_0005 -> dm_be=4'b0010, dm_we=1; a later m0 load word at 0x4 returns 0x0000AB00 (given prior zero memory).
- m0 lock=1 for 6 cycles while m1 requests continuously, MAX_BURST=4 -> m0 gets 4 grants, then m1 1 grant, then m0 resumes.
- m0 load half at 0x0000_0003 -> m0_gnt=1, dm_we=0, m0_err=1 next cycle, m0_rvalid=0.
- m1 load half at 0x0000_000A after memory word 0x8 holds 0x12345678 -> m1_rdata=0x00001234.
- Assert reset while m0 holds lock with a load in flight -> next cycle rvalid=0, state IDLE; on the next tie master 0 wins.
